// File: rtl/trail_arena_pkg.sv
// Shared definitions for the light-cycle arena: FSM encoding, empty-cell id,
// and an unsigned range helper used for head and readback coordinates.
package trail_arena_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_CHECK,
      ST_COMMIT,
      ST_DONE
   } state_t;

   localparam int OWNER_EMPTY = 0;

   // Coordinates are compared at 32 bits so an edge overrun never aliases.
   function automatic logic in_range(input int unsigned v, input int unsigned lim);
      return (v < lim);
   endfunction

endpackage

// File: rtl/arena_cell.sv
// One arena cell: holds the owner id of the trail on it (0 = empty).
// A row clear takes priority over a trail write in the same cycle.
module arena_cell #(
   parameter int ID_W = 2
) (
   input  logic            clock,
   input  logic            clrn,
   input  logic            wr_en,
   input  logic [ID_W-1:0] wr_id,
   input  logic            row_clr,
   output logic [ID_W-1:0] owner
);

   // Owner register: async wipe on reset, sync wipe on row clear, else trail write.
   // NOTE: the arena storage is reset too, since a reset must present an empty board at once.
   always_ff @(posedge clock or negedge clrn) begin
      if (!clrn) begin
         owner <= '0;
      end else if (row_clr) begin
         owner <= '0;
      end else if (wr_en) begin
         owner <= wr_id;
      end
   end

endmodule

// File: rtl/trail_arena.sv
// Light-cycle arena: GRID_W x GRID_H owner cells, one step per game tick.
// Each step latches all heads, checks live players one per cycle against the
// pre-step board (boundary, occupied cell, head-on), then commits survivors.
module trail_arena
   import trail_arena_pkg::*;
#(
   parameter int GRID_W    = 32,
   parameter int GRID_H    = 24,
   parameter int N_PLAYERS = 2,
   parameter int X_W       = $clog2(GRID_W),
   parameter int Y_W       = $clog2(GRID_H),
   parameter int ID_W      = $clog2(N_PLAYERS + 1)
) (
   input  logic                     clock,
   input  logic                     clrn,
   input  logic                     clear_req,
   input  logic                     step_valid,
   output logic                     step_ready,
   input  logic [N_PLAYERS*X_W-1:0] head_x,
   input  logic [N_PLAYERS*Y_W-1:0] head_y,
   output logic [N_PLAYERS-1:0]     alive,
   output logic [N_PLAYERS-1:0]     crash,
   output logic                     result_valid,
   input  logic [X_W-1:0]           rd_x,
   input  logic [Y_W-1:0]           rd_y,
   output logic [ID_W-1:0]          rd_owner
);

   localparam int P_W = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;

   state_t               state;
   state_t               state_nx;
   logic [Y_W-1:0]       row_cnt;
   logic [P_W-1:0]       p_cnt;
   logic [X_W-1:0]       hx_q [N_PLAYERS];
   logic [Y_W-1:0]       hy_q [N_PLAYERS];
   logic [N_PLAYERS-1:0] crash_step;
   logic [ID_W-1:0]      owner [GRID_H][GRID_W];
   logic [GRID_H-1:0]    row_clr;

   logic                 row_last;
   logic                 p_last;
   logic [X_W-1:0]       cur_x;
   logic [Y_W-1:0]       cur_y;
   logic                 cur_live;
   logic                 cur_oob;
   logic [ID_W-1:0]      cur_owner;
   logic                 cur_headon;
   logic                 crash_now;

   assign row_last = (row_cnt == Y_W'(GRID_H - 1));
   assign p_last   = (p_cnt == P_W'(N_PLAYERS - 1));

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge clrn) begin
      if (!clrn) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state and handshake outputs; clear wins over a simultaneous step.
   // NOTE: every output of this block is given a default first so no latch is inferred.
   always_comb begin
      state_nx     = state;
      step_ready   = 1'b0;
      result_valid = 1'b0;
      unique case (state)
         ST_IDLE: begin
            step_ready = 1'b1;
            if (clear_req) begin
               state_nx = ST_CLEAR;
            end else if (step_valid) begin
               state_nx = ST_CHECK;
            end
         end
         ST_CLEAR: begin
            if (row_last) state_nx = ST_IDLE;
         end
         ST_CHECK: begin
            if (p_last) state_nx = ST_COMMIT;
         end
         ST_COMMIT: begin
            state_nx = ST_DONE;
         end
         ST_DONE: begin
            result_valid = 1'b1;
            state_nx     = ST_IDLE;
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // Crash evaluation for the player currently selected by p_cnt.
   always_comb begin
      cur_x      = '0;
      cur_y      = '0;
      cur_live   = 1'b0;
      cur_headon = 1'b0;
      cur_owner  = '0;
      for (int p = 0; p < N_PLAYERS; p++) begin
         if (P_W'(p) == p_cnt) begin
            cur_x    = hx_q[p];
            cur_y    = hy_q[p];
            cur_live = alive[p];
         end
      end
      for (int q = 0; q < N_PLAYERS; q++) begin
         if ((P_W'(q) != p_cnt) && alive[q] && (hx_q[q] == cur_x) && (hy_q[q] == cur_y)) begin
            cur_headon = 1'b1;
         end
      end
      cur_oob = !(in_range(32'(cur_x), GRID_W) && in_range(32'(cur_y), GRID_H));
      if (!cur_oob) begin
         cur_owner = owner[cur_y][cur_x];
      end
      crash_now = cur_live && (cur_oob || (cur_owner != ID_W'(OWNER_EMPTY)) || cur_headon);
   end

   // Step datapath: head latch, player/row counters, crash accumulation, flag update.
   always_ff @(posedge clock or negedge clrn) begin
      if (!clrn) begin
         row_cnt    <= '0;
         p_cnt      <= '0;
         crash_step <= '0;
         alive      <= '1;
         crash      <= '0;
         for (int p = 0; p < N_PLAYERS; p++) begin
            hx_q[p] <= '0;
            hy_q[p] <= '0;
         end
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (clear_req) begin
                  row_cnt <= '0;
               end else if (step_valid) begin
                  p_cnt      <= '0;
                  crash_step <= '0;
                  for (int p = 0; p < N_PLAYERS; p++) begin
                     hx_q[p] <= head_x[p*X_W +: X_W];
                     hy_q[p] <= head_y[p*Y_W +: Y_W];
                  end
               end
            end
            ST_CLEAR: begin
               row_cnt <= row_cnt + 1'b1;
               if (row_last) begin
                  alive <= '1;
                  crash <= '0;
               end
            end
            ST_CHECK: begin
               p_cnt <= p_cnt + 1'b1;
               for (int p = 0; p < N_PLAYERS; p++) begin
                  if (P_W'(p) == p_cnt) crash_step[p] <= crash_now;
               end
            end
            ST_COMMIT: begin
               alive <= alive & ~crash_step;
               crash <= crash_step;
            end
            default: begin
            end
         endcase
      end
   end

   // Row-sweep clear strobe, one row per CLEAR cycle.
   always_comb begin
      row_clr = '0;
      for (int r = 0; r < GRID_H; r++) begin
         row_clr[r] = (state == ST_CLEAR) && (row_cnt == Y_W'(r));
      end
   end

   // Cell array with per-cell trail write decode from the surviving heads.
   for (genvar gy = 0; gy < GRID_H; gy++) begin : g_row
      for (genvar gx = 0; gx < GRID_W; gx++) begin : g_col
         logic            cell_wr_en;
         logic [ID_W-1:0] cell_wr_id;

         // Select the surviving player whose head lands on this cell.
         always_comb begin
            cell_wr_en = 1'b0;
            cell_wr_id = '0;
            if (state == ST_COMMIT) begin
               for (int p = 0; p < N_PLAYERS; p++) begin
                  if (alive[p] && !crash_step[p] &&
                      (32'(hx_q[p]) == gx) && (32'(hy_q[p]) == gy)) begin
                     cell_wr_en = 1'b1;
                     cell_wr_id = ID_W'(p + 1);
                  end
               end
            end
         end

         arena_cell #(
            .ID_W(ID_W)
         ) u_cell (
            .clock  (clock),
            .clrn   (clrn),
            .wr_en  (cell_wr_en),
            .wr_id  (cell_wr_id),
            .row_clr(row_clr[gy]),
            .owner  (owner[gy][gx])
         );
      end
   end

   // Renderer readback; out-of-range coordinates read as empty.
   always_comb begin
      rd_owner = '0;
      if (in_range(32'(rd_x), GRID_W) && in_range(32'(rd_y), GRID_H)) begin
         rd_owner = owner[rd_y][rd_x];
      end
   end

endmodule

// File: tb/tb_trail_arena.sv
// Directed bench for trail_arena with default parameters (32x24, 2 players).
// Outputs are sampled on falling edges; expected values are hand-computed.
module tb_trail_arena;

   logic       clock;
   logic       clrn;
   logic       clear_req;
   logic       step_valid;
   logic       step_ready;
   logic [9:0] head_x;
   logic [9:0] head_y;
   logic [1:0] alive;
   logic [1:0] crash;
   logic       result_valid;
   logic [4:0] rd_x;
   logic [4:0] rd_y;
   logic [1:0] rd_owner;

   int vectors     = 0;
   int miscompares = 0;

   trail_arena dut (
      .clock       (clock),
      .clrn        (clrn),
      .clear_req   (clear_req),
      .step_valid  (step_valid),
      .step_ready  (step_ready),
      .head_x      (head_x),
      .head_y      (head_y),
      .alive       (alive),
      .crash       (crash),
      .result_valid(result_valid),
      .rd_x        (rd_x),
      .rd_y        (rd_y),
      .rd_owner    (rd_owner)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, required finish before 500000");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic read_cell(input int x, input int y, output logic [1:0] o);
      rd_x = 5'(x);
      rd_y = 5'(y);
      #1;
      o = rd_owner;
   endtask

   // Counts cells owned by player 1 and player 2 over the whole board.
   task automatic sweep(output int n1, output int n2);
      logic [1:0] o;
      n1 = 0;
      n2 = 0;
      for (int y = 0; y < 24; y++) begin
         for (int x = 0; x < 32; x++) begin
            read_cell(x, y, o);
            if (o == 2'd1) n1++;
            if (o != 2'd0 && o != 2'd1) n2++;
         end
      end
   endtask

   // Presents one step; lat = falling edges from accept until result_valid (0 = never).
   task automatic run_step(input int x0, input int y0, input int x1, input int y1,
                           output int lat, output logic ready_mid);
      @(negedge clock);
      head_x     = {5'(x1), 5'(x0)};
      head_y     = {5'(y1), 5'(y0)};
      step_valid = 1'b1;
      @(posedge clock);
      #1;
      step_valid = 1'b0;
      lat        = 0;
      ready_mid  = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clock);
         if (i == 1) ready_mid = step_ready;
         if (result_valid) begin
            lat = i;
            break;
         end
      end
   endtask

   // Requests a clear (optionally with a competing step); n = cycles step_ready stayed low.
   task automatic run_clear(input logic with_step, output int n, output logic rv_seen);
      @(negedge clock);
      clear_req  = 1'b1;
      step_valid = with_step;
      head_x     = {5'd9, 5'd9};
      head_y     = {5'd8, 5'd9};
      @(posedge clock);
      #1;
      clear_req  = 1'b0;
      step_valid = 1'b0;
      n          = 0;
      rv_seen    = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         if (result_valid) rv_seen = 1'b1;
         if (step_ready) break;
         n++;
      end
   endtask

   initial begin
      int         lat;
      int         n;
      int         n1;
      int         n2;
      logic       rdy;
      logic       rv;
      logic [1:0] o;

      clrn       = 1'b1;
      clear_req  = 1'b0;
      step_valid = 1'b0;
      head_x     = '0;
      head_y     = '0;
      rd_x       = '0;
      rd_y       = '0;

      // Reset.
      #2 clrn = 1'b0;
      #1;
      check("reset_alive", alive, 2'b11);
      check("reset_crash", crash, 2'b00);
      repeat (3) @(negedge clock);
      clrn = 1'b1;
      @(negedge clock);
      check("reset_ready", step_ready, 1'b1);
      check("reset_result_valid", result_valid, 1'b0);
      sweep(n1, n2);
      check("reset_board_empty", n1 + n2, 0);

      // Two players side by side, no crash.
      run_step(3, 4, 10, 4, lat, rdy);
      check("s1_ready_low", rdy, 1'b0);
      check("s1_latency", lat, 4);
      check("s1_crash", crash, 2'b00);
      check("s1_alive", alive, 2'b11);
      read_cell(3, 4, o);
      check("s1_cell_3_4", o, 2'd1);
      read_cell(10, 4, o);
      check("s1_cell_10_4", o, 2'd2);

      // P0 drives into P1's trail.
      run_step(10, 4, 11, 4, lat, rdy);
      check("s2_latency", lat, 4);
      check("s2_crash", crash, 2'b01);
      check("s2_alive", alive, 2'b10);
      read_cell(10, 4, o);
      check("s2_cell_10_4", o, 2'd2);
      read_cell(11, 4, o);
      check("s2_cell_11_4", o, 2'd2);
      sweep(n1, n2);
      check("s2_p1_cells", n1, 1);
      check("s2_p2_cells", n2, 2);

      // Clear and step requested together: clear wins, step dropped.
      run_clear(1'b1, n, rv);
      check("clr_ready_low_cycles", n, 24);
      check("clr_no_result_valid", rv, 1'b0);
      check("clr_alive", alive, 2'b11);
      check("clr_crash", crash, 2'b00);
      sweep(n1, n2);
      check("clr_board_empty", n1 + n2, 0);

      // Head-on collision.
      run_step(7, 7, 7, 7, lat, rdy);
      check("ho_latency", lat, 4);
      check("ho_crash", crash, 2'b11);
      check("ho_alive", alive, 2'b00);
      read_cell(7, 7, o);
      check("ho_cell_7_7", o, 2'd0);

      // Everyone dead: step still completes, nothing written.
      run_step(1, 1, 2, 2, lat, rdy);
      check("dead_latency", lat, 4);
      check("dead_crash", crash, 2'b00);
      check("dead_alive", alive, 2'b00);
      sweep(n1, n2);
      check("dead_board_empty", n1 + n2, 0);

      // Boundary: P0 at y=GRID_H, P1 at the far corner.
      run_clear(1'b0, n, rv);
      check("clr2_alive", alive, 2'b11);
      run_step(5, 24, 31, 23, lat, rdy);
      check("bnd_crash", crash, 2'b01);
      check("bnd_alive", alive, 2'b10);
      read_cell(31, 23, o);
      check("bnd_cell_31_23", o, 2'd2);
      read_cell(5, 24, o);
      check("bnd_readback_oob", o, 2'd0);
      sweep(n1, n2);
      check("bnd_p1_cells", n1, 0);
      check("bnd_p2_cells", n2, 1);

      // Self crash: P1 re-enters its own trail; P0 dead is skipped.
      run_step(0, 0, 31, 23, lat, rdy);
      check("self_crash", crash, 2'b10);
      check("self_alive", alive, 2'b00);
      read_cell(0, 0, o);
      check("self_cell_0_0", o, 2'd0);

      // Reset pulse while in CHECK.
      @(negedge clock);
      head_x     = {5'd3, 5'd2};
      head_y     = {5'd3, 5'd2};
      step_valid = 1'b1;
      @(posedge clock);
      #1;
      step_valid = 1'b0;
      check("mid_ready_low", step_ready, 1'b0);
      #1 clrn = 1'b0;
      #1;
      check("mid_rst_alive", alive, 2'b11);
      check("mid_rst_crash", crash, 2'b00);
      check("mid_rst_result_valid", result_valid, 1'b0);
      read_cell(31, 23, o);
      check("mid_rst_cell_31_23", o, 2'd0);
      @(negedge clock);
      clrn = 1'b1;
      rv   = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         if (result_valid) rv = 1'b1;
      end
      check("mid_rst_no_pulse", rv, 1'b0);
      check("mid_rst_ready", step_ready, 1'b1);

      // Fresh step after reset along the top edge.
      run_step(0, 0, 31, 0, lat, rdy);
      check("post_latency", lat, 4);
      check("post_crash", crash, 2'b00);
      read_cell(0, 0, o);
      check("post_cell_0_0", o, 2'd1);
      read_cell(31, 0, o);
      check("post_cell_31_0", o, 2'd2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
